seg_led_hex595_multi: RTL and testbench

// Parametrised successor of the 4-digit 595 hex display driver. Drives DIGITS multiplexed 7-segment

---
 rtl/seg_led_pkg.sv | 21 ++
 rtl/hex_to_seg7.sv | 12 +
 rtl/seg_led_hex595_multi.sv | 212 +++++++++++++++++++++
 tb/tb_seg_led_hex595_multi.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_led_pkg.sv
// Shared constants for the 595-based multiplexed 7-segment driver: FSM state
// encodings, the hex-to-segment table and a width helper for counters.
package seg_led_pkg;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_STROBE = 2'd2;
    localparam logic [1:0] ST_DWELL  = 2'd3;

    // Segment patterns {g,f,e,d,c,b,a} for nibble values 0..F.
    localparam logic [6:0] HEX_SEG7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    // Counter width that never collapses to zero bits.
    function automatic int min_width(input int w);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble + decimal point to active-high segment byte {dp,g..a}.
module hex_to_seg7
    import seg_led_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {dp, HEX_SEG7[nibble]};

endmodule

// File: rtl/seg_led_hex595_multi.sv
// Multiplexed DIGITS-digit 7-segment driver through cascaded 74HC595s: per digit it
// shifts {segments, one-hot select} MSB first, strobes, then holds for DWELL cycles.
module seg_led_hex595_multi
    import seg_led_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int CLK_DIV     = 4,
    parameter int DWELL       = 1000,
    parameter bit SEG_ACT_LOW = 1'b1,
    parameter bit SEL_ACT_LOW = 1'b1
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic [8*DIGITS-1:0] din,
    input  logic [DIGITS-1:0]   dp,
    input  logic [DIGITS-1:0]   blank,
    input  logic                raw_mode,
    input  logic                upd_valid,
    output logic                upd_ready,
    output logic                frame_done,
    output logic                clk,
    output logic                dat,
    output logic                str
);

    localparam int FW   = 8 + DIGITS;
    localparam int PH_W = min_width($clog2(CLK_DIV + 1));
    localparam int BC_W = $clog2(FW + 1);
    localparam int DW_W = min_width($clog2(DWELL + 1));
    localparam int DG_W = min_width($clog2(DIGITS));

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(FW - 1);
    localparam logic [DW_W-1:0] DW_LAST = DW_W'(DWELL - 1);
    localparam logic [DG_W-1:0] DG_LAST = DG_W'(DIGITS - 1);

    logic [1:0]          state, state_n;
    logic [DG_W-1:0]     digit, digit_n;
    logic [PH_W-1:0]     phase, phase_n;
    logic [BC_W-1:0]     bit_cnt, bit_cnt_n;
    logic [DW_W-1:0]     dwell_cnt, dwell_cnt_n;
    logic                half, half_n;
    logic [FW-1:0]       shreg, shreg_n;
    logic                frame_done_n;

    logic [8*DIGITS-1:0] sh_din;
    logic [DIGITS-1:0]   sh_dp;
    logic [DIGITS-1:0]   sh_blank;
    logic                sh_raw;

    logic                accept;
    logic [8*DIGITS-1:0] eff_din;
    logic [DIGITS-1:0]   eff_dp;
    logic [DIGITS-1:0]   eff_blank;
    logic                eff_raw;

    logic [7:0]          cur_byte;
    logic                cur_dp;
    logic                cur_blank;
    logic [DIGITS-1:0]   sel;
    logic [7:0]          hex_seg;
    logic [7:0]          seg;
    logic [FW-1:0]       frame_word;

    // The snapshot is taken in the same LOAD that builds digit 0's word, so bypass
    // the shadow registers in that cycle to keep the whole frame on the new data.
    assign accept    = upd_valid & upd_ready;
    assign eff_din   = accept ? din      : sh_din;
    assign eff_dp    = accept ? dp       : sh_dp;
    assign eff_blank = accept ? blank    : sh_blank;
    assign eff_raw   = accept ? raw_mode : sh_raw;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        cur_byte  = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        sel       = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit == DG_W'(i)) begin
                cur_byte  = eff_din[8*i +: 8];
                cur_dp    = eff_dp[i];
                cur_blank = eff_blank[i];
                sel[i]    = 1'b1;
            end
        end
    end

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (cur_byte[3:0]),
        .dp     (cur_dp),
        .seg    (hex_seg)
    );

    always_comb begin
        seg = '0;
        if (!cur_blank) begin
            seg = eff_raw ? cur_byte : hex_seg;
        end
        frame_word = {seg ^ {8{SEG_ACT_LOW}}, sel ^ {DIGITS{SEL_ACT_LOW}}};
    end

    always_comb begin
        state_n     = state;
        digit_n     = digit;
        phase_n     = phase;
        bit_cnt_n   = bit_cnt;
        dwell_cnt_n = dwell_cnt;
        half_n      = half;
        shreg_n     = shreg;
        case (state)
            ST_LOAD: begin
                state_n   = ST_SHIFT;
                shreg_n   = frame_word;
                phase_n   = PH_LAST;
                bit_cnt_n = BC_LAST;
                half_n    = 1'b0;
            end
            ST_SHIFT: begin
                if (phase != '0) begin
                    phase_n = phase - 1'b1;
                end else begin
                    phase_n = PH_LAST;
                    if (!half) begin
                        half_n = 1'b1;
                    end else if (bit_cnt == '0) begin
                        half_n  = 1'b0;
                        state_n = ST_STROBE;
                    end else begin
                        half_n    = 1'b0;
                        bit_cnt_n = bit_cnt - 1'b1;
                        shreg_n   = {shreg[FW-2:0], 1'b0};
                    end
                end
            end
            ST_STROBE: begin
                if (phase != '0) begin
                    phase_n = phase - 1'b1;
                end else if (DWELL == 0) begin
                    state_n = ST_LOAD;
                    digit_n = (digit == DG_LAST) ? '0 : digit + 1'b1;
                end else begin
                    state_n     = ST_DWELL;
                    dwell_cnt_n = DW_LAST;
                end
            end
            default: begin
                if (dwell_cnt != '0) begin
                    dwell_cnt_n = dwell_cnt - 1'b1;
                end else begin
                    state_n = ST_LOAD;
                    digit_n = (digit == DG_LAST) ? '0 : digit + 1'b1;
                end
            end
        endcase
    end

    // Outputs are registered from next-state values so the 595 pins never glitch
    // and still line up cycle-for-cycle with the state register.
    always_comb begin
        if (DWELL > 0) begin
            frame_done_n = (state_n == ST_DWELL) && (dwell_cnt_n == '0) && (digit_n == DG_LAST);
        end else begin
            frame_done_n = (state_n == ST_STROBE) && (phase_n == '0) && (digit_n == DG_LAST);
        end
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every register
        // samples pre-edge values regardless of statement order.
        if (sys_rst) begin
            state      <= ST_LOAD;
            digit      <= '0;
            phase      <= '0;
            bit_cnt    <= '0;
            dwell_cnt  <= '0;
            half       <= 1'b0;
            shreg      <= '0;
            // NOTE: shadow registers are reset on purpose: blank=all-ones keeps the
            // display dark until the first accepted update.
            sh_din     <= '0;
            sh_dp      <= '0;
            sh_blank   <= '1;
            sh_raw     <= 1'b0;
            clk        <= 1'b0;
            dat        <= 1'b0;
            str        <= 1'b0;
            upd_ready  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            digit      <= digit_n;
            phase      <= phase_n;
            bit_cnt    <= bit_cnt_n;
            dwell_cnt  <= dwell_cnt_n;
            half       <= half_n;
            shreg      <= shreg_n;
            if (accept) begin
                sh_din   <= din;
                sh_dp    <= dp;
                sh_blank <= blank;
                sh_raw   <= raw_mode;
            end
            clk        <= (state_n == ST_SHIFT) && half_n;
            dat        <= (state_n == ST_SHIFT) && shreg_n[FW-1];
            str        <= (state_n == ST_STROBE);
            upd_ready  <= (state_n == ST_LOAD) && (digit_n == '0);
            frame_done <= frame_done_n;
        end
    end

endmodule

// File: tb/tb_seg_led_hex595_multi.sv
// Directed bench for seg_led_hex595_multi: two 4-digit instances (active-high and
// active-low polarity) fed the same inputs; serial frames are rebuilt from clk/dat/str.
module tb_seg_led_hex595_multi;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic [31:0] din = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  blank = '0;
    logic        raw_mode = 1'b0;
    logic        upd_valid = 1'b0;

    logic upd_ready, frame_done, clk_a, dat_a, str_a;
    logic upd_ready_b, frame_done_b, clk_b, dat_b, str_b;

    int checks = 0;
    int errors = 0;

    seg_led_hex595_multi #(
        .DIGITS(4), .CLK_DIV(1), .DWELL(2), .SEG_ACT_LOW(1'b0), .SEL_ACT_LOW(1'b0)
    ) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .din(din), .dp(dp), .blank(blank),
        .raw_mode(raw_mode), .upd_valid(upd_valid), .upd_ready(upd_ready),
        .frame_done(frame_done), .clk(clk_a), .dat(dat_a), .str(str_a)
    );

    seg_led_hex595_multi #(
        .DIGITS(4), .CLK_DIV(1), .DWELL(2), .SEG_ACT_LOW(1'b1), .SEL_ACT_LOW(1'b1)
    ) dut_inv (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .din(din), .dp(dp), .blank(blank),
        .raw_mode(raw_mode), .upd_valid(upd_valid), .upd_ready(upd_ready_b),
        .frame_done(frame_done_b), .clk(clk_b), .dat(dat_b), .str(str_b)
    );

    always #5 sys_clk = ~sys_clk;

    // Frame reconstruction, sampled on the falling edge.
    int          cyc = 0;
    logic [11:0] acc_a = '0, acc_b = '0, word_a = '0, word_b = '0;
    int          nb_a = 0, nbl_a = 0, fcnt_a = 0, tstr_a = 0, tprev_a = 0;
    int          fd_t = 0, fd_prev_t = 0, fd_long = 0, ready_viol = 0;
    logic        pclk_a = 0, pstr_a = 0, pclk_b = 0, pstr_b = 0, pfd = 0;

    always @(negedge sys_clk) begin
        cyc++;
        if (sys_rst) begin
            acc_a = '0; nb_a = 0; acc_b = '0;
        end else begin
            if (clk_a && !pclk_a) begin acc_a = {acc_a[10:0], dat_a}; nb_a++; end
            if (clk_b && !pclk_b) acc_b = {acc_b[10:0], dat_b};
            if (str_a && !pstr_a) begin
                word_a = acc_a; nbl_a = nb_a; acc_a = '0; nb_a = 0;
                tprev_a = tstr_a; tstr_a = cyc; fcnt_a++;
            end
            if (str_b && !pstr_b) begin word_b = acc_b; acc_b = '0; end
            if (frame_done) begin
                fd_prev_t = fd_t; fd_t = cyc;
                if (pfd) fd_long++;
            end
            if (upd_ready !== pfd) ready_viol++;
        end
        pclk_a = clk_a; pstr_a = str_a; pclk_b = clk_b; pstr_b = str_b; pfd = frame_done;
    end

    task automatic wait_frame(output logic [11:0] wa, output logic [11:0] wb, output int nb);
        int c0;
        int k;
        c0 = fcnt_a;
        k = 0;
        while (fcnt_a == c0 && k < 100) begin
            @(negedge sys_clk); #1; k++;
        end
        if (fcnt_a == c0) begin
            checks++; errors++;
            $display("FAIL frame_timeout: no strobe within %0d cycles", k);
        end
        wa = word_a; wb = word_b; nb = nbl_a;
    endtask

    task automatic wait_accept();
        int k;
        k = 0;
        while (upd_ready !== 1'b1 && k < 300) begin
            @(negedge sys_clk); #1; k++;
        end
        if (upd_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL accept_timeout: upd_ready never rose in %0d cycles", k);
        end
        @(posedge sys_clk); #1;
        upd_valid = 1'b0;
    endtask

    task automatic do_update(input logic [31:0] d, input logic [3:0] p, input logic [3:0] b, input logic r);
        din = d; dp = p; blank = b; raw_mode = r; upd_valid = 1'b1;
        wait_accept();
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        #1;
        checks++;
        if ({clk_a, dat_a, str_a, upd_ready, frame_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 00000", {clk_a, dat_a, str_a, upd_ready, frame_done});
        end
        checks++;
        if ({clk_b, dat_b, str_b, upd_ready_b, frame_done_b} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs_inv: got %b required 00000", {clk_b, dat_b, str_b, upd_ready_b, frame_done_b});
        end
        sys_rst = 1'b0;
    endtask

    task automatic test_blank_start();
        logic [11:0] wa, wb;
        int nb;
        wait_frame(wa, wb, nb);
        checks++;
        if (wa !== 12'b0000_0000_0001) begin
            errors++; $display("FAIL blank_d0: got %b required 000000000001", wa);
        end
        checks++;
        if (nb !== 12) begin
            errors++; $display("FAIL blank_d0_bits: got %0d required 12", nb);
        end
        checks++;
        if (wb !== 12'b1111_1111_1110) begin
            errors++; $display("FAIL blank_d0_inv: got %b required 111111111110", wb);
        end
        wait_frame(wa, wb, nb);
        checks++;
        if (wa !== 12'b0000_0000_0010) begin
            errors++; $display("FAIL blank_d1: got %b required 000000000010", wa);
        end
    endtask

    task automatic test_hex();
        logic [11:0] wa, wb;
        int nb;
        do_update(32'h0000_000A, 4'b0000, 4'b0000, 1'b0);
        wait_frame(wa, wb, nb);
        checks++;
        if (wa !== 12'b0111_0111_0001) begin
            errors++; $display("FAIL hex_d0: got %b required 011101110001", wa);
        end
        checks++;
        if (tstr_a - fd_t !== 26) begin
            errors++; $display("FAIL hex_str_latency: got %0d required 26", tstr_a - fd_t);
        end
        checks++;
        if (wb !== 12'b1000_1000_1110) begin
            errors++; $display("FAIL hex_d0_inv: got %b required 100010001110", wb);
        end
        wait_frame(wa, wb, nb);
        checks++;
        if (wa !== 12'b0011_1111_0010) begin
            errors++; $display("FAIL hex_d1: got %b required 001111110010", wa);
        end
        checks++;
        if (tstr_a - tprev_a !== 28) begin
            errors++; $display("FAIL digit_period: got %0d required 28", tstr_a - tprev_a);
        end
    endtask

    task automatic test_dp();
        logic [11:0] wa, wb;
        int nb;
        do_update(32'h0000_080A, 4'b0010, 4'b0000, 1'b0);
        wait_frame(wa, wb, nb);
        checks++;
        if (wa !== 12'b0111_0111_0001) begin
            errors++; $display("FAIL dp_d0: got %b required 011101110001", wa);
        end
        wait_frame(wa, wb, nb);
        checks++;
        if (wa !== 12'b1111_1111_0010) begin
            errors++; $display("FAIL dp_d1: got %b required 111111110010", wa);
        end
    endtask

    task automatic test_raw_blank();
        logic [11:0] wa, wb;
        int nb;
        do_update(32'h005A_080A, 4'b1111, 4'b0000, 1'b1);
        wait_frame(wa, wb, nb);
        checks++;
        if (wa !== 12'b0000_1010_0001) begin
            errors++; $display("FAIL raw_d0: got %b required 000010100001", wa);
        end
        wait_frame(wa, wb, nb);
        checks++;
        if (wa !== 12'b0000_1000_0010) begin
            errors++; $display("FAIL raw_d1: got %b required 000010000010", wa);
        end
        wait_frame(wa, wb, nb);
        checks++;
        if (wa !== 12'b0101_1010_0100) begin
            errors++; $display("FAIL raw_d2: got %b required 010110100100", wa);
        end
        do_update(32'h005A_080A, 4'b1111, 4'b0100, 1'b1);
        repeat (3) wait_frame(wa, wb, nb);
        checks++;
        if (wa !== 12'b0000_0000_0100) begin
            errors++; $display("FAIL raw_d2_blank: got %b required 000000000100", wa);
        end
    endtask

    task automatic test_polarity();
        logic [11:0] wa, wb;
        int nb;
        do_update(32'h0000_0000, 4'b0000, 4'b0000, 1'b0);
        repeat (4) wait_frame(wa, wb, nb);
        checks++;
        if (wb !== 12'b1100_0000_0111) begin
            errors++; $display("FAIL pol_d3_inv: got %b required 110000000111", wb);
        end
        checks++;
        if (wa !== 12'b0011_1111_1000) begin
            errors++; $display("FAIL pol_d3: got %b required 001111111000", wa);
        end
    endtask

    task automatic test_mid_frame_update();
        logic [11:0] wa, wb;
        int nb;
        int k;
        k = 0;
        wa = '0;
        while (wa[3:0] !== 4'b0010 && k < 5) begin
            wait_frame(wa, wb, nb); k++;
        end
        checks++;
        if (upd_ready !== 1'b0) begin
            errors++; $display("FAIL mid_ready_low: got %b required 0", upd_ready);
        end
        din = 32'h1111_1111; dp = 4'b0000; blank = 4'b0000; raw_mode = 1'b0; upd_valid = 1'b1;
        wait_frame(wa, wb, nb);
        checks++;
        if (wa !== 12'b0011_1111_0100) begin
            errors++; $display("FAIL mid_d2_old: got %b required 001111110100", wa);
        end
        wait_frame(wa, wb, nb);
        checks++;
        if (wa !== 12'b0011_1111_1000) begin
            errors++; $display("FAIL mid_d3_old: got %b required 001111111000", wa);
        end
        wait_accept();
        wait_frame(wa, wb, nb);
        checks++;
        if (wa !== 12'b0000_0110_0001) begin
            errors++; $display("FAIL mid_d0_new: got %b required 000001100001", wa);
        end
        checks++;
        if (fd_t - fd_prev_t !== 112) begin
            errors++; $display("FAIL frame_period: got %0d required 112", fd_t - fd_prev_t);
        end
        checks++;
        if (ready_viol !== 0) begin
            errors++; $display("FAIL ready_outside_load0: got %0d cycles required 0", ready_viol);
        end
        checks++;
        if (fd_long !== 0) begin
            errors++; $display("FAIL frame_done_width: got %0d long pulses required 0", fd_long);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [11:0] wa, wb;
        int nb;
        int k;
        k = 0;
        while (frame_done !== 1'b1 && k < 200) begin
            @(negedge sys_clk); #1; k++;
        end
        checks++;
        if (frame_done !== 1'b1) begin
            errors++; $display("FAIL rst_fd_timeout: got %b required 1", frame_done);
        end
        repeat (12) begin @(negedge sys_clk); #1; end
        checks++;
        if ({clk_a, dat_a} !== 2'b01) begin
            errors++; $display("FAIL rst_bit5_state: got clk,dat=%b required 01", {clk_a, dat_a});
        end
        sys_rst = 1'b1;
        @(negedge sys_clk); #1;
        checks++;
        if ({clk_a, dat_a, str_a, upd_ready, frame_done} !== 5'b0) begin
            errors++; $display("FAIL rst_mid_outputs: got %b required 00000", {clk_a, dat_a, str_a, upd_ready, frame_done});
        end
        sys_rst = 1'b0;
        wait_frame(wa, wb, nb);
        checks++;
        if (wa !== 12'b0000_0000_0001 || nb !== 12) begin
            errors++; $display("FAIL rst_restart_d0: got %b (%0d bits) required 000000000001 (12 bits)", wa, nb);
        end
        checks++;
        if (ready_viol !== 0) begin
            errors++; $display("FAIL rst_ready_viol: got %0d required 0", ready_viol);
        end
    endtask

    initial begin
        test_reset();
        test_blank_start();
        test_hex();
        test_dp();
        test_raw_blank();
        test_polarity();
        test_mid_frame_update();
        test_reset_mid_shift();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
